// File: rtl/logic_processor_pkg.sv
// Shared state encoding and routing-select constants for the bit-serial logic processor.
package logic_processor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      HALT  = 2'b10
   } ctrl_state_t;

   localparam logic [1:0] ROUTE_KEEP   = 2'b00;
   localparam logic [1:0] ROUTE_F_TO_B = 2'b01;
   localparam logic [1:0] ROUTE_F_TO_A = 2'b10;
   localparam logic [1:0] ROUTE_SWAP   = 2'b11;

endpackage

// File: rtl/op_counter.sv
// Shift-cycle counter for one operation: clears to zero, counts up while enabled,
// saturates at WIDTH and flags the final shift cycle.
module op_counter #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] count,
   output logic          last
);

   localparam logic [CW-1:0] MAX_VAL  = CW'(WIDTH);
   localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != MAX_VAL)) begin
         count <= count + 1'b1;
      end
   end

   // High during the cycle whose increment completes the operation.
   assign last = (count == LAST_VAL);

endmodule

// File: rtl/logic_processor_controller.sv
// Sequencer for the bit-serial logic processor: one execute press runs WIDTH shift
// cycles with a frozen routing select, then halts until execute is released.
module logic_processor_controller
   import logic_processor_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          execute,
   input  logic          load_a,
   input  logic          load_b,
   input  logic [1:0]    routing_sel_in,
   output logic          ld_a,
   output logic          ld_b,
   output logic          shift_en,
   output logic [1:0]    routing_select,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] shift_count
);

   ctrl_state_t state_reg;
   ctrl_state_t state_next;
   logic [1:0]  sel_reg;
   logic        cnt_clear;
   logic        cnt_en;
   logic        cnt_last;

   op_counter #(.WIDTH(WIDTH)) u_op_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .count  (shift_count),
      .last   (cnt_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         sel_reg   <= ROUTE_KEEP;
      end else begin
         state_reg <= state_next;
         if ((state_reg == IDLE) && execute) begin
            sel_reg <= routing_sel_in;
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_clear      = 1'b0;
      cnt_en         = 1'b0;
      ld_a           = 1'b0;
      ld_b           = 1'b0;
      shift_en       = 1'b0;
      routing_select = ROUTE_KEEP;
      busy           = 1'b0;
      done           = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_clear = 1'b1;
            if (execute) begin
               state_next = SHIFT;
            end else begin
               // Loads only reach the registers when no operation is being launched.
               ld_a = load_a;
               ld_b = load_b;
            end
         end
         SHIFT: begin
            shift_en       = 1'b1;
            busy           = 1'b1;
            routing_select = sel_reg;
            cnt_en         = 1'b1;
            if (cnt_last) begin
               state_next = HALT;
            end
         end
         HALT: begin
            done = 1'b1;
            if (!execute) begin
               state_next = IDLE;
               cnt_clear  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_logic_processor_controller.sv
// Directed bench for logic_processor_controller: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_logic_processor_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       execute = 1'b0;
   logic       load_a = 1'b0;
   logic       load_b = 1'b0;
   logic [1:0] routing_sel_in = 2'b00;
   logic       ld_a, ld_b, shift_en, busy, done;
   logic [1:0] routing_select;
   logic [3:0] shift_count;

   logic       exec_w1 = 1'b0;
   logic       load_a_w1 = 1'b0;
   logic       load_b_w1 = 1'b0;
   logic [1:0] sel_in_w1 = 2'b00;
   logic       ld_a_w1, ld_b_w1, shift_en_w1, busy_w1, done_w1;
   logic [1:0] routing_select_w1;
   logic [0:0] shift_count_w1;

   int checks = 0;
   int errors = 0;

   // {ld_a, ld_b, busy, done, shift_en, routing_select, shift_count}
   logic [10:0] stat;
   assign stat = {ld_a, ld_b, busy, done, shift_en, routing_select, shift_count};
   // {ld_a, ld_b, busy, done, shift_en, routing_select, shift_count}
   logic [7:0] stat_w1;
   assign stat_w1 = {ld_a_w1, ld_b_w1, busy_w1, done_w1, shift_en_w1, routing_select_w1, shift_count_w1};

   always #5 clk = ~clk;

   logic_processor_controller #(.WIDTH(8)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .execute        (execute),
      .load_a         (load_a),
      .load_b         (load_b),
      .routing_sel_in (routing_sel_in),
      .ld_a           (ld_a),
      .ld_b           (ld_b),
      .shift_en       (shift_en),
      .routing_select (routing_select),
      .busy           (busy),
      .done           (done),
      .shift_count    (shift_count)
   );

   logic_processor_controller #(.WIDTH(1)) u_dut_w1 (
      .clk            (clk),
      .reset          (reset),
      .execute        (exec_w1),
      .load_a         (load_a_w1),
      .load_b         (load_b_w1),
      .routing_sel_in (sel_in_w1),
      .ld_a           (ld_a_w1),
      .ld_b           (ld_b_w1),
      .shift_en       (shift_en_w1),
      .routing_select (routing_select_w1),
      .busy           (busy_w1),
      .done           (done_w1),
      .shift_count    (shift_count_w1)
   );

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (stat !== 11'd0) begin
         errors++;
         $display("FAIL reset_initial got %b exp %b", stat, 11'd0);
      end
      reset = 1'b0;
      execute = 1'b1;
      routing_sel_in = 2'b01;
      @(negedge clk);
      execute = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (stat !== {2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 4'd3}) begin
         errors++;
         $display("FAIL reset_pre_shift3 got %b exp %b", stat, {2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 4'd3});
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (stat !== 11'd0) begin
         errors++;
         $display("FAIL reset_mid_shift got %b exp %b", stat, 11'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (stat !== 11'd0) begin
         errors++;
         $display("FAIL reset_stays_idle got %b exp %b", stat, 11'd0);
      end
      $display("reset: async reset during SHIFT count=3 returns to IDLE");
   endtask

   task automatic test_burst(input logic [1:0] sel, input logic [1:0] sel_change);
      logic [10:0] exp;
      execute = 1'b1;
      routing_sel_in = sel;
      @(negedge clk);
      execute = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp = {2'b00, 1'b1, 1'b0, 1'b1, sel, 4'(i)};
         checks++;
         if (stat !== exp) begin
            errors++;
            $display("FAIL burst_shift%0d got %b exp %b", i, stat, exp);
         end
         if (i == 2) routing_sel_in = sel_change;
         @(negedge clk);
      end
      exp = {2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 4'd8};
      checks++;
      if (stat !== exp) begin
         errors++;
         $display("FAIL burst_halt got %b exp %b", stat, exp);
      end
      @(negedge clk);
      checks++;
      if (stat !== 11'd0) begin
         errors++;
         $display("FAIL burst_back_idle got %b exp %b", stat, 11'd0);
      end
      $display("burst: sel=%b changed to %b mid-run, 8 shifts then HALT", sel, sel_change);
   endtask

   task automatic test_held();
      int n;
      n = 0;
      execute = 1'b1;
      routing_sel_in = 2'b11;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (shift_en === 1'b1) n++;
      end
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL held_shift_cycles got %0d exp %0d", n, 8);
      end
      checks++;
      if (stat !== {2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 4'd8}) begin
         errors++;
         $display("FAIL held_halt got %b exp %b", stat, {2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 4'd8});
      end
      execute = 1'b0;
      @(negedge clk);
      checks++;
      if (stat !== 11'd0) begin
         errors++;
         $display("FAIL held_release_idle got %b exp %b", stat, 11'd0);
      end
      $display("held: execute high 20 cycles gave %0d shifts, then IDLE on release", n);
      test_burst(2'b10, 2'b00);
   endtask

   task automatic test_loads();
      load_a = 1'b1;
      #1;
      checks++;
      if ({ld_a, ld_b} !== 2'b10) begin
         errors++;
         $display("FAIL load_a_pass got %b exp %b", {ld_a, ld_b}, 2'b10);
      end
      load_a = 1'b0;
      load_b = 1'b1;
      #1;
      checks++;
      if ({ld_a, ld_b} !== 2'b01) begin
         errors++;
         $display("FAIL load_b_pass got %b exp %b", {ld_a, ld_b}, 2'b01);
      end
      load_a = 1'b1;
      load_b = 1'b0;
      execute = 1'b1;
      routing_sel_in = 2'b01;
      #1;
      checks++;
      if ({ld_a, ld_b} !== 2'b00) begin
         errors++;
         $display("FAIL load_exec_priority got %b exp %b", {ld_a, ld_b}, 2'b00);
      end
      @(negedge clk);
      execute = 1'b0;
      load_b = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({ld_a, ld_b, busy} !== 3'b001) begin
            errors++;
            $display("FAIL load_in_shift%0d got %b exp %b", i, {ld_a, ld_b, busy}, 3'b001);
         end
         @(negedge clk);
      end
      checks++;
      if ({ld_a, ld_b, done} !== 3'b001) begin
         errors++;
         $display("FAIL load_in_halt got %b exp %b", {ld_a, ld_b, done}, 3'b001);
      end
      @(negedge clk);
      checks++;
      if ({ld_a, ld_b, busy, done} !== 4'b1100) begin
         errors++;
         $display("FAIL load_after_idle got %b exp %b", {ld_a, ld_b, busy, done}, 4'b1100);
      end
      load_a = 1'b0;
      load_b = 1'b0;
      $display("loads: pass-through in IDLE only, suppressed by execute and in SHIFT/HALT");
   endtask

   task automatic test_width1();
      exec_w1 = 1'b1;
      sel_in_w1 = 2'b11;
      @(negedge clk);
      exec_w1 = 1'b0;
      checks++;
      if (stat_w1 !== {2'b00, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0}) begin
         errors++;
         $display("FAIL w1_shift got %b exp %b", stat_w1, {2'b00, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0});
      end
      @(negedge clk);
      checks++;
      if (stat_w1 !== {2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1}) begin
         errors++;
         $display("FAIL w1_halt got %b exp %b", stat_w1, {2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1});
      end
      @(negedge clk);
      checks++;
      if (stat_w1 !== 8'd0) begin
         errors++;
         $display("FAIL w1_idle got %b exp %b", stat_w1, 8'd0);
      end
      $display("width1: single shift cycle, shift_count=1, done, then IDLE");
   endtask

   initial begin
      test_reset();
      test_burst(2'b01, 2'b11);
      test_held();
      test_loads();
      test_width1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
